cfifo_sync_param: RTL

- Parametrised single-clock circular FIFO. Next generation of the team's 8-bit x 32 circular FIFO.
- Configurable data width and depth. Adds occupancy count, almost-full/almost-empty thresholds, sticky overflow/underflow error flags and a synchronous flush.
- Read data path has a read-valid qualifier, and the output holds its value between reads instead of returning to zero.
- Sits between a producer and consumer in the same clock domain. Replaces the hand-built JK counter pointers with wrap-bit binary pointers.

---
 rtl/cfifo_pkg.sv | 28 ++
 rtl/cfifo_ptr.sv | 49 ++++
 rtl/cfifo_sync_param.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/cfifo_pkg.sv
// ----------------------------------------------------------------------------
// cfifo_pkg
// Shared definitions for the cfifo family of circular FIFOs.
//   cfifo_depth()    : number of words for a given address width
//   cfifo_ptr_w()    : width of a wrap-bit pointer (address bits + wrap bit)
//   cfifo_status_t   : status flag bundle, ordered
//                      {overflow, underflow, almost_full, almost_empty, full, empty}
// ----------------------------------------------------------------------------
package cfifo_pkg;

  function automatic int cfifo_depth(input int addr_width);
    return 1 << addr_width;
  endfunction

  function automatic int cfifo_ptr_w(input int addr_width);
    return addr_width + 1;
  endfunction

  typedef struct packed {
    logic overflow;
    logic underflow;
    logic almost_full;
    logic almost_empty;
    logic full;
    logic empty;
  } cfifo_status_t;

endpackage

// File: rtl/cfifo_ptr.sv
// ----------------------------------------------------------------------------
// cfifo_ptr
// Wrap-bit binary pointer for a circular FIFO. The MSB is the wrap bit, the
// low ADDR_WIDTH bits address the storage array. Counts modulo
// 2**(ADDR_WIDTH+1).
// Ports:
//   clk     in   clock, rising edge
//   reset_n in   asynchronous active-low reset (pointer -> 0)
//   flush   in   synchronous clear (pointer -> 0), overrides inc
//   inc     in   advance pointer by one
//   ptr     out  current pointer value, ADDR_WIDTH+1 bits
// ----------------------------------------------------------------------------
module cfifo_ptr
  import cfifo_pkg::*;
#(
  parameter int ADDR_WIDTH = 5
) (
  input  logic                               clk,
  input  logic                               reset_n,
  input  logic                               flush,
  input  logic                               inc,
  output logic [cfifo_ptr_w(ADDR_WIDTH)-1:0] ptr
);

  localparam int PTR_W = cfifo_ptr_w(ADDR_WIDTH);

  logic [PTR_W-1:0] ptr_q;
  logic [PTR_W-1:0] ptr_d;

  always_comb begin
    ptr_d = ptr_q;
    if (flush) begin
      ptr_d = '0;
    end else if (inc) begin
      ptr_d = ptr_q + PTR_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign ptr = ptr_q;

endmodule

// File: rtl/cfifo_sync_param.sv
// ----------------------------------------------------------------------------
// cfifo_sync_param
// Parametrised single-clock circular FIFO with occupancy count, almost
// thresholds, sticky overflow/underflow flags and synchronous flush.
//
// Build option: define CFIFO_FWFT_EN for first-word-fall-through output
// (head word presented combinationally, rd_valid = !EMPTY). Without it the
// read path is registered: data_out updates one cycle after an accepted read
// and holds otherwise, rd_valid pulses for that one cycle.
//
// Ports:
//   clk          in   clock, rising edge
//   reset_n      in   asynchronous active-low reset
//   flush        in   synchronous clear of pointers and rd_valid
//   w_en         in   write request
//   data_in      in   write data [DATA_WIDTH]
//   r_en         in   read (pop) request
//   data_out     out  read data [DATA_WIDTH]
//   rd_valid     out  data_out carries a popped / presented word
//   FULL         out  count == DEPTH
//   EMPTY        out  count == 0
//   almost_full  out  count >= AF_THRESH
//   almost_empty out  count <= AE_THRESH
//   count        out  occupancy 0..DEPTH [ADDR_WIDTH+1]
//   overflow     out  sticky, write attempted while FULL
//   underflow    out  sticky, read attempted while EMPTY
//   clr_err      in   synchronous clear of overflow/underflow
// ----------------------------------------------------------------------------
module cfifo_sync_param
  import cfifo_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 5,
  parameter int AF_THRESH  = 28,
  parameter int AE_THRESH  = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  flush,
  input  logic                  w_en,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  r_en,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  rd_valid,
  output logic                  FULL,
  output logic                  EMPTY,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  overflow,
  output logic                  underflow,
  input  logic                  clr_err
);

  localparam int DEPTH = cfifo_depth(ADDR_WIDTH);
  localparam int PTR_W = cfifo_ptr_w(ADDR_WIDTH);
  localparam logic [PTR_W-1:0] AF_T = PTR_W'(AF_THRESH);
  localparam logic [PTR_W-1:0] AE_T = PTR_W'(AE_THRESH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic [PTR_W-1:0]      w_ptr;
  logic [PTR_W-1:0]      r_ptr;
  logic [ADDR_WIDTH-1:0] w_idx;
  logic [ADDR_WIDTH-1:0] r_idx;
  logic [PTR_W-1:0]      count_w;
  logic                  full_w;
  logic                  empty_w;
  logic                  wr_acc;
  logic                  rd_acc;
  cfifo_status_t         status;

  logic overflow_q;
  logic overflow_d;
  logic underflow_q;
  logic underflow_d;

  assign w_idx   = w_ptr[ADDR_WIDTH-1:0];
  assign r_idx   = r_ptr[ADDR_WIDTH-1:0];
  assign empty_w = (w_ptr == r_ptr);
  // Same slot but opposite laps: the writer is exactly one lap ahead.
  assign full_w  = (w_idx == r_idx) && (w_ptr[ADDR_WIDTH] != r_ptr[ADDR_WIDTH]);
  assign count_w = w_ptr - r_ptr;

  // flush drops both requests for the cycle.
  assign wr_acc = w_en && !full_w  && !flush;
  assign rd_acc = r_en && !empty_w && !flush;

  cfifo_ptr #(.ADDR_WIDTH(ADDR_WIDTH)) u_w_ptr (
    .clk     (clk),
    .reset_n (reset_n),
    .flush   (flush),
    .inc     (wr_acc),
    .ptr     (w_ptr)
  );

  cfifo_ptr #(.ADDR_WIDTH(ADDR_WIDTH)) u_r_ptr (
    .clk     (clk),
    .reset_n (reset_n),
    .flush   (flush),
    .inc     (rd_acc),
    .ptr     (r_ptr)
  );

  // Storage is never reset so it maps onto plain RAM.
  always_ff @(posedge clk) begin
    if (wr_acc) begin
      mem[w_idx] <= data_in;
    end
  end

  // Sticky errors: a new error in the same cycle as clr_err wins. A flush
  // cycle leaves the flags untouched.
  always_comb begin
    overflow_d  = overflow_q;
    underflow_d = underflow_q;
    if (!flush) begin
      if (clr_err) begin
        overflow_d  = 1'b0;
        underflow_d = 1'b0;
      end
      if (w_en && full_w) begin
        overflow_d = 1'b1;
      end
      if (r_en && empty_w) begin
        underflow_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

`ifdef CFIFO_FWFT_EN
  // Head word is always presented; when empty it is a stale memory word.
  assign data_out = mem[r_idx];
  assign rd_valid = !empty_w;
`else
  logic [DATA_WIDTH-1:0] data_out_q;
  logic [DATA_WIDTH-1:0] data_out_d;
  logic                  rd_valid_q;
  logic                  rd_valid_d;

  always_comb begin
    data_out_d = data_out_q;
    rd_valid_d = rd_acc;
    if (rd_acc) begin
      data_out_d = mem[r_idx];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_out_q <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      data_out_q <= data_out_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  assign data_out = data_out_q;
  assign rd_valid = rd_valid_q;
`endif

  always_comb begin
    status              = '0;
    status.overflow     = overflow_q;
    status.underflow    = underflow_q;
    status.almost_full  = (count_w >= AF_T);
    status.almost_empty = (count_w <= AE_T);
    status.full         = full_w;
    status.empty        = empty_w;
  end

  assign overflow     = status.overflow;
  assign underflow    = status.underflow;
  assign almost_full  = status.almost_full;
  assign almost_empty = status.almost_empty;
  assign FULL         = status.full;
  assign EMPTY        = status.empty;
  assign count        = count_w;

endmodule
